// File: rtl/ram_dump_tx.sv
// Dumps a contiguous range of 32-bit words from the data memory's extra read port
// over a UART 8N1 line, four bytes per word, most significant byte first.
module ram_dump_tx #(
    parameter int BAUD_DIV = 868,
    parameter int ADDR_W   = 12
) (
    input  logic              clk_in,
    input  logic              RST,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] word_count,
    output logic [ADDR_W-1:0] extra_addr,
    input  logic [31:0]       extra_dout,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_START,
        S_DATA,
        S_STOP,
        S_NEXT
    } state_t;

    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

    state_t            state, state_n;
    logic [15:0]       baud_cnt, baud_cnt_n;
    logic [2:0]        bit_idx, bit_idx_n;
    logic [1:0]        byte_idx, byte_idx_n;
    logic [31:0]       tx_word, tx_word_n;
    logic [ADDR_W-1:0] remaining, remaining_n;
    logic [ADDR_W-1:0] addr_n;
    logic              tx_n, busy_n, done_n;
    logic              baud_last;

    assign baud_last = (baud_cnt == BAUD_LAST);

    always_comb begin
        state_n     = state;
        baud_cnt_n  = baud_cnt;
        bit_idx_n   = bit_idx;
        byte_idx_n  = byte_idx;
        tx_word_n   = tx_word;
        remaining_n = remaining;
        addr_n      = extra_addr;
        busy_n      = busy;
        done_n      = 1'b0;
        tx_n        = 1'b1;

        case (state)
            S_IDLE: begin
                busy_n = 1'b0;
                if (start) begin
                    addr_n = start_addr;
                    if (word_count == '0) begin
                        done_n = 1'b1;
                    end else begin
                        remaining_n = word_count;
                        busy_n      = 1'b1;
                        state_n     = S_FETCH;
                    end
                end
            end
            S_FETCH: state_n = S_LATCH;
            S_LATCH: begin
                tx_word_n  = extra_dout;
                byte_idx_n = 2'd3;
                bit_idx_n  = '0;
                baud_cnt_n = '0;
                state_n    = S_START;
            end
            S_START: begin
                if (baud_last) begin
                    baud_cnt_n = '0;
                    bit_idx_n  = '0;
                    state_n    = S_DATA;
                end else begin
                    baud_cnt_n = baud_cnt + 16'd1;
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    baud_cnt_n = '0;
                    if (bit_idx == 3'd7) state_n = S_STOP;
                    else                 bit_idx_n = bit_idx + 3'd1;
                end else begin
                    baud_cnt_n = baud_cnt + 16'd1;
                end
            end
            S_STOP: begin
                if (baud_last) begin
                    baud_cnt_n = '0;
                    if (byte_idx != 2'd0) begin
                        byte_idx_n = byte_idx - 2'd1;
                        state_n    = S_START;
                    end else begin
                        state_n = S_NEXT;
                    end
                end else begin
                    baud_cnt_n = baud_cnt + 16'd1;
                end
            end
            S_NEXT: begin
                remaining_n = remaining - 1'b1;
                if (remaining == ADDR_W'(1)) begin
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = S_IDLE;
                end else begin
                    addr_n  = extra_addr + 1'b1;
                    state_n = S_FETCH;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // tx is registered, so its next level is decoded from the state being entered
        case (state_n)
            S_START: tx_n = 1'b0;
            S_DATA:  tx_n = tx_word_n[{byte_idx_n, bit_idx_n}];
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (RST) begin
            state      <= S_IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            byte_idx   <= '0;
            tx_word    <= '0;
            remaining  <= '0;
            extra_addr <= '0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            baud_cnt   <= baud_cnt_n;
            bit_idx    <= bit_idx_n;
            byte_idx   <= byte_idx_n;
            tx_word    <= tx_word_n;
            remaining  <= remaining_n;
            extra_addr <= addr_n;
            tx         <= tx_n;
            busy       <= busy_n;
            done       <= done_n;
        end
    end

endmodule

// File: tb/tb_ram_dump_tx.sv
// Self-checking bench for ram_dump_tx: per-cycle timing model of the serial dump
// plus an independent UART receiver and literal expectations for directed cases.
module tb_ram_dump_tx;

    localparam int B  = 4;
    localparam int AW = 12;
    localparam int P  = 40 * B + 3;  // cycles per word including the 3 gap cycles

    logic          clk_in = 1'b0;
    logic          RST;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW-1:0] word_count;
    logic [AW-1:0] extra_addr;
    logic [31:0]   extra_dout;
    logic          tx;
    logic          busy;
    logic          done;

    logic [31:0] mem [4096];

    int errors = 0;
    int checks = 0;

    always #5 clk_in = ~clk_in;

    assign extra_dout = mem[extra_addr];

    ram_dump_tx #(.BAUD_DIV(B), .ADDR_W(AW)) dut (
        .clk_in     (clk_in),
        .RST        (RST),
        .start      (start),
        .start_addr (start_addr),
        .word_count (word_count),
        .extra_addr (extra_addr),
        .extra_dout (extra_dout),
        .tx         (tx),
        .busy       (busy),
        .done       (done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a dump of N words from address A is a timeline indexed by
    // t = cycles since start was accepted.
    logic        running = 1'b0;
    logic        idle_en = 1'b0;
    int          t = 0;
    int          m_a = 0;
    int          m_n = 0;
    logic [31:0] cur_word = '0;
    int          addr_log[$];
    logic [7:0]  rxq[$];

    always @(negedge clk_in) begin
        int   ed, w, u, bp, bi;
        logic exp_tx;
        if (running) begin
            t++;
            ed = m_n * P + 1;
            w  = (t - 1) / P;
            if (t >= 2 && (t - 2) % P == 0 && w < m_n) cur_word = mem[(m_a + w) % 4096];
            if (t >= 1 && (t - 1) % P == 0 && w < m_n) addr_log.push_back(int'(extra_addr));
            exp_tx = 1'b1;
            u = t - (3 + w * P);
            if (t < ed && u >= 0 && u < 40 * B) begin
                bi = u / (10 * B);
                bp = (u % (10 * B)) / B;
                if (bp == 0)      exp_tx = 1'b0;
                else if (bp <= 8) exp_tx = cur_word[(3 - bi) * 8 + bp - 1];
            end
            chk("tx", tx, exp_tx);
            chk("busy", busy, t < ed);
            chk("done", done, t == ed);
            if (t < ed) chk("extra_addr", extra_addr, (m_a + w) % 4096);
            if (t >= ed || RST === 1'b1) running = 1'b0;
        end else if (idle_en) begin
            chk("idle_tx", tx, 1);
            chk("idle_busy", busy, 0);
            chk("idle_done", done, 0);
        end
        if (!running && idle_en && start === 1'b1 && RST === 1'b0) begin
            running = 1'b1;
            t       = 0;
            m_a     = int'(start_addr);
            m_n     = int'(word_count);
        end
    end

    // Independent UART receiver, sampling each bit one cycle into its period
    int         rc = -1;
    logic [7:0] rsh = '0;

    always @(negedge clk_in) begin
        if (RST !== 1'b0) begin
            rc = -1;
        end else if (rc < 0) begin
            if (tx === 1'b0) rc = 0;
        end else begin
            rc++;
            if (rc % B == 1 && rc / B >= 1 && rc / B <= 8) begin
                rsh[rc / B - 1] = tx;
            end else if (rc == 9 * B + 1) begin
                chk("rx_stop", tx, 1);
                rxq.push_back(rsh);
                rc = -1;
            end
        end
    end

    task automatic launch(input int a, input int n);
        @(posedge clk_in); #1;
        start      = 1'b1;
        start_addr = AW'(a);
        word_count = AW'(n);
        @(posedge clk_in); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int maxc, output int lat);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        while (!seen && lat < maxc) begin
            @(negedge clk_in);
            lat++;
            if (done === 1'b1) seen = 1'b1;
        end
        if (!seen) chk("done_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic chk_word(input string name, input int idx, input logic [31:0] w);
        for (int k = 0; k < 4; k++) chk(name, rxq[idx + k], w[31 - 8 * k -: 8]);
    endtask

    initial begin
        int          lat, rb, ab, a, n;
        logic [31:0] w0, w1;
        RST        = 1'b1;
        start      = 1'b0;
        start_addr = '0;
        word_count = '0;
        for (int i = 0; i < 4096; i++) mem[i] = $urandom;
        repeat (3) @(posedge clk_in);
        #1 RST = 1'b0;
        @(negedge clk_in);
        chk("reset_tx", tx, 1);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_addr", extra_addr, 0);
        idle_en = 1'b1;

        // Single word
        mem[12'h010] = 32'h12345678;
        rb = rxq.size();
        launch(12'h010, 1);
        wait_done(P + 20, lat);
        chk("single_latency", lat, 164);
        idle(8);
        chk("single_nbytes", rxq.size() - rb, 4);
        chk_word("single_byte", rb, 32'h12345678);

        // Multi-word with address wrap
        mem[12'hFFE] = 32'h0000000A;
        mem[12'hFFF] = 32'h0000000B;
        mem[12'h000] = 32'h0000000C;
        rb = rxq.size();
        ab = addr_log.size();
        launch(12'hFFE, 3);
        wait_done(3 * P + 20, lat);
        chk("wrap_latency", lat, 490);
        idle(8);
        chk("wrap_nbytes", rxq.size() - rb, 12);
        chk("wrap_addr0", addr_log[ab], 12'hFFE);
        chk("wrap_addr1", addr_log[ab + 1], 12'hFFF);
        chk("wrap_addr2", addr_log[ab + 2], 12'h000);
        chk_word("wrap_word0", rb, 32'h0000000A);
        chk_word("wrap_word2", rb + 8, 32'h0000000C);

        // Zero count
        rb = rxq.size();
        launch(12'h055, 0);
        wait_done(5, lat);
        chk("zero_latency", lat, 1);
        idle(30);
        chk("zero_nbytes", rxq.size() - rb, 0);

        // Start while busy is ignored
        w0 = $urandom;
        w1 = $urandom;
        mem[12'h200] = w0;
        mem[12'h201] = w1;
        rb = rxq.size();
        launch(12'h200, 2);
        repeat (49) @(posedge clk_in);
        #1;
        start      = 1'b1;
        start_addr = 12'h100;
        word_count = 12'd5;
        @(posedge clk_in); #1;
        start = 1'b0;
        wait_done(2 * P + 20, lat);
        idle(P + 10);
        chk("busy_start_nbytes", rxq.size() - rb, 8);
        chk_word("busy_start_word0", rb, w0);
        chk_word("busy_start_word1", rb + 4, w1);

        // Reset during data bit 3 of the second byte
        launch(12'h300, 2);
        repeat (58) @(posedge clk_in);
        #1 RST = 1'b1;
        @(posedge clk_in);
        #1 RST = 1'b0;
        @(negedge clk_in);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        idle(20);
        w0 = $urandom;
        mem[12'h400] = w0;
        rb = rxq.size();
        launch(12'h400, 1);
        wait_done(P + 20, lat);
        chk("after_rst_latency", lat, 164);
        idle(8);
        chk("after_rst_nbytes", rxq.size() - rb, 4);
        chk_word("after_rst_word", rb, w0);

        // Memory write after capture does not affect the transmitted word
        mem[12'h020] = 32'h00000001;
        rb = rxq.size();
        launch(12'h020, 1);
        repeat (2) @(posedge clk_in);
        #1 mem[12'h020] = 32'h00000002;
        wait_done(P + 20, lat);
        idle(8);
        chk_word("isolation_word", rb, 32'h00000001);

        // Randomized dumps
        for (int r = 0; r < 4; r++) begin
            a = int'($urandom_range(0, 4095));
            n = int'($urandom_range(1, 3));
            for (int i = 0; i < n; i++) mem[(a + i) % 4096] = $urandom;
            rb = rxq.size();
            launch(a, n);
            wait_done(n * P + 20, lat);
            chk("rand_latency", lat, n * P + 1);
            idle(8);
            chk("rand_nbytes", rxq.size() - rb, 4 * n);
            for (int i = 0; i < n; i++) chk_word("rand_word", rb + 4 * i, mem[(a + i) % 4096]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_dump_tx.md
# ram_dump_tx

Serial read-out engine for the data memory's auxiliary read port. On command, it walks a contiguous range of word addresses through the extra port (`extra_addr` / `extra_dout`), fetches each 32-bit word, and transmits it as four UART 8N1 bytes, most significant byte first, on a single `tx` line. The CPU side writes the memory through the main port. This block is the external reader at the other end, so board-level tools can capture RAM contents after a program halts.

## Interface
Parameters:
- `BAUD_DIV`, default 868: clock cycles per UART bit, for example 100 MHz / 115200. Legal range is 2..65535.
- `ADDR_W`, default 12: width of the word address on the extra port.

Ports:
- `clk_in`, input, 1: the single clock for the block. All state updates on its rising edge.
- `RST`, input, 1: synchronous, active-high reset.
- `start`, input, 1: one-cycle request to begin a dump. Sampled only in IDLE.
- `start_addr`, input, ADDR_W: first word address. Latched when `start` is accepted.
- `word_count`, input, ADDR_W: number of words to send. Latched when `start` is accepted.
- `extra_addr`, output, ADDR_W: read address driven to the data memory's extra port.
- `extra_dout`, input, 32: combinational read data returned by the extra port.
- `tx`, output, 1: UART line. Idle level is high.
- `busy`, output, 1: high from the cycle after `start` is accepted until the dump finishes.
- `done`, output, 1: one-cycle pulse when a dump completes.

## Operation
- Reset values: state IDLE, `tx`=1, `busy`=0, `done`=0, `extra_addr`=0, internal counters=0.
- States:
  - IDLE
  - FETCH: `extra_addr` is driven and the block waits one cycle for the read data.
  - LATCH: `extra_dout` is captured into the 32-bit shift word.
  - START
  - DATA
  - STOP
  - NEXT
- IDLE:
  - On `start`=1, latch `start_addr` into `extra_addr` and latch `word_count`.
  - If the latched count is 0, go straight to a `done` pulse next cycle with no transmission; `busy` stays 0.
  - Otherwise go to FETCH.
- FETCH → LATCH → START. The byte index is set to 3, meaning bits [31:24] go out first.
- START: `tx`=0 for `BAUD_DIV` cycles, then DATA.
- DATA: 8 bits of the current byte, LSB first. Each bit is held for `BAUD_DIV` cycles. Then STOP.
- STOP: `tx`=1 for `BAUD_DIV` cycles. Then:
  - if the byte index is greater than 0, decrement it and go to START, so bytes are sent back-to-back;
  - otherwise go to NEXT.
- NEXT:
  - Decrement the remaining word count.
  - If it reaches 0: assert `done` for one cycle, drop `busy` in the same cycle, and return to IDLE.
  - Else: `extra_addr` += 1, go to FETCH.
- Address arithmetic is modulo 2^ADDR_W, so 4095 wraps to 0 with the default width.
- Word count is unsigned, so the maximum is 2^ADDR_W − 1 words.
- `start` asserted while `busy`=1 is ignored; it is neither queued nor allowed to restart the dump.
- `extra_dout` is sampled only in LATCH. Memory writes to an address after it is latched do not affect the transmitted value.
- A `RST` asserted mid-frame wins over everything else. At the next edge:
  - `tx`=1, `busy`=0, and no `done` pulse;
  - the partial frame is abandoned.
- `done` and `busy` are registered outputs.

## Timing
- `start` sampled at edge k:
  - `busy`=1 and `extra_addr`=`start_addr` from k+1 (FETCH);
  - the word is captured at k+2 (LATCH);
  - the `tx` start bit begins at k+3.
- One byte frame takes 10·`BAUD_DIV` cycles; one word takes 40·`BAUD_DIV` cycles of line time.
- Between words, `tx` stays high for 3 cycles (NEXT, FETCH, LATCH) in addition to the stop bit.
- Total time from `start` to `done` for N ≥ 1 words: 3 + N·40·`BAUD_DIV` + 3·(N−1) + 1 cycles.
- `done` is high for exactly one cycle and is never asserted while `busy` is high in the same cycle.

## Test plan
- **Single word.** `BAUD_DIV`=4, RAM[0x010]=0x12345678, start_addr=0x010, count=1.
  - `tx` decodes to bytes 0x12, 0x34, 0x56, 0x78.
  - `done` arrives exactly 164 cycles after `start`.
- **Multi-word and address wrap.** start_addr=0xFFE, count=3, RAM[0xFFE]=0xA, RAM[0xFFF]=0xB, RAM[0x000]=0xC.
  - `extra_addr` sequence is 0xFFE, 0xFFF, 0x000.
  - 12 bytes are received, ending 00 00 00 0C.
- **Zero count.** count=0: `busy` stays 0, a `done` pulse occurs at k+1, and `tx` is constantly 1.
- **Start while busy.** A second `start` pulse with start_addr=0x100 during word 1 of a 2-word dump is ignored.
  - Only the original two words are sent; exactly one `done` pulse occurs.
- **Reset mid-frame.** `RST` is asserted during DATA bit 3 of byte 2.
  - Next edge: `tx`=1, `busy`=0, no `done`.
  - A following `start` dumps correctly from the new start_addr.
- **Sample isolation.** RAM[0x020] is overwritten from 0x1 to 0x2 one cycle after LATCH; the transmitted word is 0x00000001.
